cpu_sequencer: RTL

//  Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. Holds the instruction register (IR) and drives IR to the

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/cpu_sequencer_if.sv | 37 +++
 rtl/cpu_sequencer_timer.sv | 31 +++
 rtl/cpu_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: FSM states, opcodes, timer width.
package cpu_pkg;

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, STEP_WAIT, FAULT
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_LI    = 4'h7;
  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;
  localparam logic [3:0] OP_NOT   = 4'hA;

  function automatic logic is_mem_op(logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // 1011-1111 are undefined and must never write the register file
  function automatic logic is_defined_op(logic [3:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> memories/decoder/datapath bus. The step input exists only with SINGLE_STEP_EN.
interface cpu_sequencer_if;
  logic [7:0] instr_in;
  logic       imem_req;
  logic       imem_ready;
  logic [7:0] ir;
  logic       ctrl_reg_write;
  logic       ctrl_mem_write;
  logic       ctrl_mem_to_reg;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready;
  logic       rf_we;
  logic       pc_en;
  logic       pc_sel;
  logic       busy;
  logic       fault;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  modport master (
    output imem_req, ir, dmem_req, dmem_we, rf_we, pc_en, pc_sel, busy, fault,
    input  instr_in, imem_ready, ctrl_reg_write, ctrl_mem_write, ctrl_mem_to_reg, dmem_ready
`ifdef SINGLE_STEP_EN
    , input step
`endif
  );

  modport slave (
    input  imem_req, ir, dmem_req, dmem_we, rf_we, pc_en, pc_sel, busy, fault,
    output instr_in, imem_ready, ctrl_reg_write, ctrl_mem_write, ctrl_mem_to_reg, dmem_ready
`ifdef SINGLE_STEP_EN
    , output step
`endif
  );
endinterface

// File: rtl/cpu_sequencer_timer.sv
// bus_wait_timer: counts cycles a request waits with ready low; expired when the
// count reaches TIMEOUT_CYC and ready is still low (a ready in that cycle wins).
module bus_wait_timer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic pending,
  input  logic ready,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // count only while stalled; any ready or dropped request restarts from zero
  always_comb begin
    cnt_d = '0;
    if (pending && !ready) cnt_d = cnt_q + TMR_W'(1);
  end

  // wait counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = pending && !ready && (cnt_q == TMR_W'(TIMEOUT_CYC));

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute FSM for the 8-bit CPU. Memory ops spend their
// EXEC cycle on address generation before MEM, giving 4 cycles for ALU-class and
// 5 for LOAD/STORE. Optional single-step mode: define SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 15,
  parameter logic [7:0] NOP_OPCODE  = 8'h00
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       armed_q, armed_d;   // 0 until the first clock after reset, holds off the first fetch
  logic       imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_sel, busy, fault;
  logic       expired, step_go;
  logic [3:0] op;

  assign op = ir_q[7:4];

`ifdef SINGLE_STEP_EN
  assign step_go = bus.step;
`else
  assign step_go = 1'b0;
`endif

  // one timer serves both fetch and data phases; only one request is ever pending
  bus_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .pending (imem_req | dmem_req),
    .ready   (imem_req ? bus.imem_ready : bus.dmem_ready),
    .expired (expired)
  );

  // state-decoded requests and strobes; readies never reach outputs directly
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    busy     = 1'b1;
    fault    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = armed_q;
        busy     = armed_q;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.ctrl_mem_write;
      end
      WB: begin
        pc_en  = 1'b1;
        rf_we  = (bus.ctrl_reg_write | bus.ctrl_mem_to_reg) & is_defined_op(op);
        pc_sel = (op == OP_JUMP);
      end
      STEP_WAIT: busy  = 1'b0;
      FAULT:     fault = 1'b1;
      default: ;
    endcase
  end

  // next state, IR capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    armed_d = 1'b1;
    case (state_q)
      FETCH: begin
        if (armed_q) begin
          if (bus.imem_ready) begin
            ir_d    = bus.instr_in;
            state_d = DECODE;
          end else if (expired) begin
            state_d = FAULT;
          end
        end
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = is_mem_op(op) ? MEM : WB;
      MEM: begin
        if (bus.dmem_ready)   state_d = WB;
        else if (expired)     state_d = FAULT;
      end
`ifdef SINGLE_STEP_EN
      WB:        state_d = STEP_WAIT;
      STEP_WAIT: if (step_go) state_d = FETCH;
`else
      WB:        state_d = FETCH;
`endif
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  // state, IR and fetch-arm registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= NOP_OPCODE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      armed_q <= armed_d;
    end
  end

  assign bus.imem_req = imem_req;
  assign bus.ir       = ir_q;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.rf_we    = rf_we;
  assign bus.pc_en    = pc_en;
  assign bus.pc_sel   = pc_sel;
  assign bus.busy     = busy;
  assign bus.fault    = fault;

endmodule
